// File: rtl/branch_target_if.sv
// ---------------------------------------------------------------------------
// branch_target_if
// Purpose : bundles the decode-side branch operands and the redirect/status
//           outputs of branch_target_unit into one interface.
// Modports: master - decode / pipeline control (drives operands, advance, flush)
//           slave  - branch_target_unit (drives busy, redirect, link, error)
// Signals : br_valid, br_op[2:0], imm[IMM_W], pc_plus4[ADDR_W], rs_val[32],
//           rt_val[32], advance, flush            (master -> slave)
//           busy, redirect_valid, redirect_pc[ADDR_W], link_we,
//           link_addr[ADDR_W], err_bdslot         (slave -> master)
// ---------------------------------------------------------------------------
interface branch_target_if #(
    parameter int ADDR_W = 32,
    parameter int IMM_W  = 16
);
    logic              br_valid;
    logic [2:0]        br_op;
    logic [IMM_W-1:0]  imm;
    logic [ADDR_W-1:0] pc_plus4;
    logic [31:0]       rs_val;
    logic [31:0]       rt_val;
    logic              advance;
    logic              flush;

    logic              busy;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              link_we;
    logic [ADDR_W-1:0] link_addr;
    logic              err_bdslot;

    modport master (
        output br_valid, br_op, imm, pc_plus4, rs_val, rt_val, advance, flush,
        input  busy, redirect_valid, redirect_pc, link_we, link_addr, err_bdslot
    );

    modport slave (
        input  br_valid, br_op, imm, pc_plus4, rs_val, rt_val, advance, flush,
        output busy, redirect_valid, redirect_pc, link_we, link_addr, err_bdslot
    );
endinterface

// File: rtl/branch_target_unit.sv
// ---------------------------------------------------------------------------
// branch_target_unit
// Purpose : resolves MIPS BEQ/BNE/REGIMM-family branches, computes
//           target = pc_plus4 + (sext(imm) << SHIFT) (mod 2^ADDR_W), steps
//           through the branch delay slot and then issues a redirect to fetch.
// Ports   : clk    - rising-edge clock
//           rst_n  - asynchronous active-low reset
//           br_if  - branch_target_if.slave (operands in, redirect/status out)
// Config  : BRANCH_LINK_EN - when defined, BLTZAL/BGEZAL (ops 6/7) pulse
//           link_we on accept and link_addr = pc_plus4 + 4; when undefined
//           they resolve like BLTZ/BGEZ and link_we/link_addr are tied to 0.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | no branch pending; decode may present a branch
// DELAY    | taken branch captured; waiting for the delay slot to advance
// REDIRECT | redirect_valid high until the pipeline advances
// ---------------------------------------------------------------------------
module branch_target_unit #(
    parameter int ADDR_W = 32,
    parameter int IMM_W  = 16,
    parameter int SHIFT  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    branch_target_if.slave  br_if
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DELAY    = 2'd1;
    localparam logic [1:0] S_REDIRECT = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
    logic              err_q, err_d;
    logic              link_we_q, link_we_d;

    logic [ADDR_W-1:0] imm_ext;
    logic [ADDR_W-1:0] target;
    logic              taken;
    logic              accept;

    assign imm_ext = {{(ADDR_W-IMM_W){br_if.imm[IMM_W-1]}}, br_if.imm};
    assign target  = (imm_ext << SHIFT) + br_if.pc_plus4;

    // Ops 6/7 resolve exactly like 4/5; linking only adds the link write.
    always_comb begin
        taken = 1'b0;
        case (br_if.br_op)
            3'd0:       taken = (br_if.rs_val == br_if.rt_val);
            3'd1:       taken = (br_if.rs_val != br_if.rt_val);
            3'd2:       taken = ($signed(br_if.rs_val) <= 32'sd0);
            3'd3:       taken = ($signed(br_if.rs_val) >  32'sd0);
            3'd4, 3'd6: taken = ($signed(br_if.rs_val) <  32'sd0);
            default:    taken = ($signed(br_if.rs_val) >= 32'sd0);
        endcase
    end

    assign accept = br_if.br_valid & br_if.advance & ~br_if.flush;

    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        err_d         = 1'b0;
        link_we_d     = 1'b0;
        if (br_if.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept && taken) begin
                        state_d       = S_DELAY;
                        redirect_pc_d = target;
                    end
`ifdef BRANCH_LINK_EN
                    link_we_d = accept & (br_if.br_op[2:1] == 2'b11);
`endif
                end
                S_DELAY: begin
                    if (br_if.advance) begin
                        state_d = S_REDIRECT;
                        // A branch sitting in the delay slot is illegal; flag and drop it.
                        err_d   = br_if.br_valid;
                    end
                end
                S_REDIRECT: begin
                    if (br_if.advance) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            redirect_pc_q <= '0;
            err_q         <= 1'b0;
            link_we_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            err_q         <= err_d;
            link_we_q     <= link_we_d;
        end
    end

    assign br_if.busy           = (state_q != S_IDLE);
    assign br_if.redirect_valid = (state_q == S_REDIRECT);
    assign br_if.redirect_pc    = redirect_pc_q;
    assign br_if.err_bdslot     = err_q;
    assign br_if.link_we        = link_we_q;

`ifdef BRANCH_LINK_EN
    assign br_if.link_addr = br_if.pc_plus4 + ADDR_W'(4);
`else
    assign br_if.link_addr = '0;
`endif

endmodule

// File: tb/tb_branch_target_unit.sv
module tb_branch_target_unit;
    localparam int ADDR_W = 32;
    localparam int IMM_W  = 16;
    localparam int SHIFT  = 2;
`ifdef BRANCH_LINK_EN
    localparam bit LINK_EN = 1'b1;
`else
    localparam bit LINK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    branch_target_if #(.ADDR_W(ADDR_W), .IMM_W(IMM_W)) bif ();

    branch_target_unit #(.ADDR_W(ADDR_W), .IMM_W(IMM_W), .SHIFT(SHIFT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .br_if (bif)
    );

    typedef struct {
        logic [2:0]  op;
        logic [15:0] imm;
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] rt;
        bit          taken;
        logic [31:0] tgt;
    } vec_t;

    vec_t vecs[17];

    // behavioural reference: phase 0 = nothing pending, 1 = delay slot owed,
    // 2 = fetch must be redirected
    int          m_phase;
    logic [31:0] m_pc;
    bit          m_err;
    bit          m_link;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_target(input logic [15:0] imm, input logic [31:0] pc);
        longint off;
        longint sum;
        off = longint'($signed(imm)) * (longint'(1) << SHIFT);
        sum = longint'({32'd0, pc}) + off;
        return sum[31:0];
    endfunction

    function automatic bit ref_taken(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        int s;
        s = $signed(rs);
        case (op)
            3'd0:       return rs == rt;
            3'd1:       return rs != rt;
            3'd2:       return s <= 0;
            3'd3:       return s > 0;
            3'd4, 3'd6: return s < 0;
            default:    return s >= 0;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_pc    = '0;
        m_err   = 1'b0;
        m_link  = 1'b0;
    endtask

    task automatic model_edge();
        m_err  = 1'b0;
        m_link = 1'b0;
        if (bif.flush) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (bif.br_valid && bif.advance) begin
                m_link = LINK_EN && (bif.br_op >= 3'd6);
                if (ref_taken(bif.br_op, bif.rs_val, bif.rt_val)) begin
                    m_pc    = ref_target(bif.imm, bif.pc_plus4);
                    m_phase = 1;
                end
            end
        end else if (m_phase == 1) begin
            if (bif.advance) begin
                m_err   = bif.br_valid;
                m_phase = 2;
            end
        end else begin
            if (bif.advance) m_phase = 0;
        end
    endtask

    task automatic set_in(input bit bv, input logic [2:0] op, input logic [15:0] imm,
                          input logic [31:0] pc, input logic [31:0] rs, input logic [31:0] rt,
                          input bit adv, input bit fl);
        bif.br_valid = bv;
        bif.br_op    = op;
        bif.imm      = imm;
        bif.pc_plus4 = pc;
        bif.rs_val   = rs;
        bif.rt_val   = rt;
        bif.advance  = adv;
        bif.flush    = fl;
    endtask

    task automatic set_idle(input bit adv);
        set_in(1'b0, 3'd0, 16'd0, 32'd0, 32'd0, 32'd0, adv, 1'b0);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        set_idle(1'b0);
        #5;
        rst_n = 1'b1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".busy"},   32'(bif.busy),           32'(m_phase != 0));
        check({tag, ".rv"},     32'(bif.redirect_valid), 32'(m_phase == 2));
        check({tag, ".rpc"},    bif.redirect_pc,         m_pc);
        check({tag, ".err"},    32'(bif.err_bdslot),     32'(m_err));
        check({tag, ".linkwe"}, 32'(bif.link_we),        32'(m_link));
        check({tag, ".linka"},  bif.link_addr,           LINK_EN ? bif.pc_plus4 + 32'd4 : 32'd0);
    endtask

    // enters REDIRECT with target 48 (BEQ 5==5, imm 8, pc_plus4 16)
    task automatic to_redirect();
        set_in(1'b1, 3'd0, 16'd8, 32'd16, 32'd5, 32'd5, 1'b1, 1'b0);
        tick();
        set_idle(1'b1);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{3'd0, 16'd8,      32'd16,         32'd5,          32'd5, 1'b1, 32'd48};
        vecs[1]  = '{3'd1, 16'hFFF8,   32'd40,         32'd1,          32'd2, 1'b1, 32'd8};
        vecs[2]  = '{3'd1, 16'h7FFF,   32'd8,          32'd1,          32'd2, 1'b1, 32'd131076};
        vecs[3]  = '{3'd1, 16'h8000,   32'd160000,     32'd1,          32'd2, 1'b1, 32'd28928};
        vecs[4]  = '{3'd5, 16'd1,      32'hFFFFFFFC,   32'd0,          32'd0, 1'b1, 32'd0};
        vecs[5]  = '{3'd3, 16'd4,      32'd100,        32'd0,          32'd0, 1'b0, 32'd0};
        vecs[6]  = '{3'd2, 16'd2,      32'd100,        32'd0,          32'd9, 1'b1, 32'd108};
        vecs[7]  = '{3'd2, 16'd2,      32'd100,        32'd1,          32'd0, 1'b0, 32'd0};
        vecs[8]  = '{3'd3, 16'hFFFF,   32'd100,        32'd1,          32'd0, 1'b1, 32'd96};
        vecs[9]  = '{3'd4, 16'd3,      32'd0,          32'h80000000,   32'd0, 1'b1, 32'd12};
        vecs[10] = '{3'd4, 16'd3,      32'd0,          32'd0,          32'd0, 1'b0, 32'd0};
        vecs[11] = '{3'd5, 16'd3,      32'd0,          32'hFFFFFFFF,   32'd0, 1'b0, 32'd0};
        vecs[12] = '{3'd0, 16'd3,      32'd0,          32'd5,          32'd6, 1'b0, 32'd0};
        vecs[13] = '{3'd1, 16'd3,      32'd0,          32'd7,          32'd7, 1'b0, 32'd0};
        vecs[14] = '{3'd6, 16'd3,      32'd100,        32'd1,          32'd0, 1'b0, 32'd0};
        vecs[15] = '{3'd7, 16'd4,      32'd200,        32'd0,          32'd0, 1'b1, 32'd216};
        vecs[16] = '{3'd6, 16'd0,      32'd300,        32'hFFFFFFFF,   32'd0, 1'b1, 32'd300};

        // reset state
        rst_n = 1'b0;
        model_reset();
        set_idle(1'b0);
        #12;
        check("rst.busy",   32'(bif.busy),           32'd0);
        check("rst.rv",     32'(bif.redirect_valid), 32'd0);
        check("rst.rpc",    bif.redirect_pc,         32'd0);
        check("rst.err",    32'(bif.err_bdslot),     32'd0);
        check("rst.linkwe", 32'(bif.link_we),        32'd0);
        check("rst.linka",  bif.link_addr,           32'd0);
        rst_n = 1'b1;

        // table vectors: present, delay slot, redirect cycle
        for (int i = 0; i < 17; i++) begin
            set_in(1'b1, vecs[i].op, vecs[i].imm, vecs[i].pc, vecs[i].rs, vecs[i].rt, 1'b1, 1'b0);
            tick();
            check($sformatf("v%0d.busy", i),   32'(bif.busy),           32'(vecs[i].taken));
            check($sformatf("v%0d.rv0", i),    32'(bif.redirect_valid), 32'd0);
            check($sformatf("v%0d.linkwe", i), 32'(bif.link_we),        32'(LINK_EN && vecs[i].op >= 3'd6));
            check($sformatf("v%0d.linka", i),  bif.link_addr,           LINK_EN ? vecs[i].pc + 32'd4 : 32'd0);
            if (vecs[i].taken) check($sformatf("v%0d.rpc", i), bif.redirect_pc, vecs[i].tgt);
            set_idle(1'b1);
            tick();
            check($sformatf("v%0d.rv1", i),    32'(bif.redirect_valid), 32'(vecs[i].taken));
            check($sformatf("v%0d.linkoff", i), 32'(bif.link_we),       32'd0);
            tick();
            check($sformatf("v%0d.done", i),   32'(bif.busy | bif.redirect_valid), 32'd0);
        end

        // stalls in DELAY and REDIRECT, branch in the delay slot
        set_in(1'b1, 3'd0, 16'd8, 32'd16, 32'd5, 32'd5, 1'b1, 1'b0);
        tick();
        set_idle(1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stallD%0d.busy", i), 32'(bif.busy),           32'd1);
            check($sformatf("stallD%0d.rv", i),   32'(bif.redirect_valid), 32'd0);
        end
        set_in(1'b1, 3'd0, 16'd100, 32'd500, 32'd1, 32'd1, 1'b1, 1'b0);
        tick();
        check("bds.err", 32'(bif.err_bdslot),     32'd1);
        check("bds.rpc", bif.redirect_pc,         32'd48);
        check("bds.rv",  32'(bif.redirect_valid), 32'd1);
        set_idle(1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stallR%0d.rv", i),  32'(bif.redirect_valid), 32'd1);
            check($sformatf("stallR%0d.err", i), 32'(bif.err_bdslot),     32'd0);
            check($sformatf("stallR%0d.rpc", i), bif.redirect_pc,         32'd48);
        end
        set_idle(1'b1);
        tick();
        check("stallR.clear", 32'(bif.redirect_valid | bif.busy), 32'd0);

        // flush together with advance in DELAY
        set_in(1'b1, 3'd0, 16'd8, 32'd16, 32'd5, 32'd5, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 3'd0, 16'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        tick();
        check("flushD.busy", 32'(bif.busy), 32'd0);
        set_idle(1'b1);
        tick();
        check("flushD.rv", 32'(bif.redirect_valid), 32'd0);

        // flush in REDIRECT while stalled
        to_redirect();
        check("flushR.pre", 32'(bif.redirect_valid), 32'd1);
        set_in(1'b0, 3'd0, 16'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        tick();
        check("flushR.rv", 32'(bif.redirect_valid), 32'd0);

        // flush beats a taken branch in IDLE
        set_in(1'b1, 3'd0, 16'd20, 32'd1000, 32'd3, 32'd3, 1'b1, 1'b1);
        tick();
        check("flushI.busy", 32'(bif.busy),  32'd0);
        check("flushI.rpc",  bif.redirect_pc, 32'd48);

        // branch without advance is not captured
        set_in(1'b1, 3'd0, 16'd20, 32'd1000, 32'd3, 32'd3, 1'b0, 1'b0);
        tick();
        check("stallI.busy", 32'(bif.busy),  32'd0);
        check("stallI.rpc",  bif.redirect_pc, 32'd48);

        // asynchronous reset in REDIRECT
        set_idle(1'b1);
        tick();
        to_redirect();
        set_idle(1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rstR.rv",   32'(bif.redirect_valid), 32'd0);
        check("rstR.busy", 32'(bif.busy),           32'd0);
        check("rstR.rpc",  bif.redirect_pc,         32'd0);
        rst_n = 1'b1;

        // link branch not taken
        set_in(1'b1, 3'd6, 16'd8, 32'd100, 32'd1, 32'd0, 1'b1, 1'b0);
        tick();
        check("link.we",   32'(bif.link_we),        32'(LINK_EN));
        check("link.addr", bif.link_addr,           LINK_EN ? 32'd104 : 32'd0);
        check("link.busy", 32'(bif.busy),           32'd0);
        set_idle(1'b1);
        tick();
        check("link.pulse", 32'(bif.link_we), 32'd0);

        // randomized run against the reference model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] rs;
            logic [31:0] rt;
            case ($urandom_range(0, 4))
                0: rs = 32'd0;
                1: rs = 32'd1;
                2: rs = 32'hFFFFFFFF;
                3: rs = 32'h80000000;
                default: rs = $urandom;
            endcase
            rt = ($urandom_range(0, 1) == 0) ? rs : $urandom;
            set_in(1'(($urandom_range(0, 2)) != 0), 3'($urandom_range(0, 7)), 16'($urandom),
                   $urandom, rs, rt, 1'(($urandom_range(0, 3)) != 0), 1'(($urandom_range(0, 15)) == 0));
            tick();
            check_model($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
